tbl_ram_arbiter: RTL and testbench

- Shares one simple dual-port table RAM (port A write, port B read) between NUM_REQ lookup requesters and one control-path writer.
- Reads are granted round-robin, one per cycle. Read responses return after a fixed RD_LAT, with a one-hot requester tag.
- Sits between the lookup engines of a match/action stage and its table RAM instance.
- Guarantees read-after-write ordering on address collisions.

---
 rtl/tbl_ram_pkg.sv | 20 ++
 rtl/rr_arb.sv | 55 +++++
 rtl/tbl_ram_arbiter.sv | 124 ++++++++++++
 tb/tb_tbl_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbl_ram_pkg.sv
// Shared constants and helpers for the table-RAM arbiter and the stage arbiters
// that reuse its round-robin core.
package tbl_ram_pkg;

  localparam int DEF_ADDR_BITS = 5;
  localparam int DEF_DATA_BITS = 38;
  localparam int MAX_NUM_REQ   = 8;
  localparam int RD_LAT_MIN    = 1;
  localparam int RD_LAT_MAX    = 3;

  // Response tags are one-hot, one bit per requester.
  function automatic int tag_width(input int num_req);
    return num_req;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin grant with an external hold; the pointer only moves on a
// real grant, so a held candidate keeps its priority.
module rr_arb
  import tbl_ram_pkg::*;
#(
  parameter  int N     = 2,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_hold,
  output logic             o_cand_valid,
  output logic [IDX_W-1:0] o_cand_idx,
  output logic [N-1:0]     o_grant
);

  logic [IDX_W-1:0] r_ptr;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    o_cand_valid = 1'b0;
    o_cand_idx   = '0;
    // Search from the pointer up, then wrap to the indices below it.
    for (int k = 0; k < N; k++) begin
      if (!o_cand_valid && i_req[k] && (IDX_W'(k) >= r_ptr)) begin
        o_cand_valid = 1'b1;
        o_cand_idx   = IDX_W'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!o_cand_valid && i_req[k] && (IDX_W'(k) < r_ptr)) begin
        o_cand_valid = 1'b1;
        o_cand_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int k = 0; k < N; k++) begin
      o_grant[k] = o_cand_valid && !i_hold && (o_cand_idx == IDX_W'(k));
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (|o_grant) begin
      r_ptr <= (o_cand_idx == IDX_W'(N - 1)) ? '0 : o_cand_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tbl_ram_arbiter.sv
// Shares a simple dual-port table RAM between NUM_REQ round-robin readers and
// one never-stalling writer, stalling reads that hit a write from this or the
// previous cycle. Define TBL_RAM_ARB_STATS_EN to add saturating stat counters.
module tbl_ram_arbiter
  import tbl_ram_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int NUM_REQ   = 2,
  parameter int RD_LAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           rd_req_valid,
  output logic [NUM_REQ-1:0]           rd_req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0] rd_req_addr,
  output logic [NUM_REQ-1:0]           rd_rsp_valid,
  output logic [DATA_BITS-1:0]         rd_rsp_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_BITS-1:0]         wr_addr,
  input  logic [DATA_BITS-1:0]         wr_data,
  output logic [ADDR_BITS-1:0]         ram_addra,
  output logic [DATA_BITS-1:0]         ram_dina,
  output logic                         ram_ena,
  output logic                         ram_wea,
  output logic [ADDR_BITS-1:0]         ram_addrb,
  output logic                         ram_enb,
  input  logic [DATA_BITS-1:0]         ram_doutb
`ifdef TBL_RAM_ARB_STATS_EN
  ,
  output logic [31:0]                  stat_rd_grants,
  output logic [31:0]                  stat_wr_count,
  output logic [31:0]                  stat_stall_cycles
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int TAG_W = tag_width(NUM_REQ);

  logic                 w_wr_acc;
  logic                 w_cand_valid;
  logic [IDX_W-1:0]     w_cand_idx;
  logic [ADDR_BITS-1:0] w_cand_addr;
  logic                 w_collide;
  logic                 w_hold;
  logic [NUM_REQ-1:0]   w_grant;

  logic                 r_lw_valid;
  logic [ADDR_BITS-1:0] r_lw_addr;
  logic [TAG_W-1:0]     r_tag [RD_LAT];

  assign w_wr_acc    = wr_valid & ~rst;
  assign w_cand_addr = rd_req_addr[int'(w_cand_idx) * ADDR_BITS +: ADDR_BITS];

  // A read must not overtake a write to the same entry still landing in the RAM.
  assign w_collide = w_cand_valid &&
                     ((w_wr_acc && (wr_addr == w_cand_addr)) ||
                      (r_lw_valid && (r_lw_addr == w_cand_addr)));
  assign w_hold    = rst | w_collide;

  rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .clk          (clk),
    .rst          (rst),
    .i_req        (rd_req_valid),
    .i_hold       (w_hold),
    .o_cand_valid (w_cand_valid),
    .o_cand_idx   (w_cand_idx),
    .o_grant      (w_grant)
  );

  // NOTE: the tag pipeline is tiny and must be flushed so no stale response escapes reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lw_valid <= 1'b0;
      r_lw_addr  <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_lw_valid <= w_wr_acc;
      r_lw_addr  <= wr_addr;
      r_tag[0]   <= w_grant;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign rd_req_ready = w_grant;
  assign rd_rsp_valid = rst ? '0 : r_tag[RD_LAT-1];
  assign rd_rsp_data  = (|rd_rsp_valid) ? ram_doutb : '0;

  assign wr_ready  = ~rst;
  assign ram_ena   = w_wr_acc;
  assign ram_wea   = w_wr_acc;
  assign ram_addra = w_wr_acc ? wr_addr : '0;
  assign ram_dina  = w_wr_acc ? wr_data : '0;

  assign ram_enb   = |w_grant;
  assign ram_addrb = ram_enb ? w_cand_addr : '0;

`ifdef TBL_RAM_ARB_STATS_EN
  logic [31:0] r_stat_rd_grants;
  logic [31:0] r_stat_wr_count;
  logic [31:0] r_stat_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_rd_grants    <= '0;
      r_stat_wr_count     <= '0;
      r_stat_stall_cycles <= '0;
    end else begin
      if (ram_enb && (r_stat_rd_grants != '1))
        r_stat_rd_grants <= r_stat_rd_grants + 32'd1;
      if (w_wr_acc && (r_stat_wr_count != '1))
        r_stat_wr_count <= r_stat_wr_count + 32'd1;
      if ((|rd_req_valid) && !ram_enb && (r_stat_stall_cycles != '1))
        r_stat_stall_cycles <= r_stat_stall_cycles + 32'd1;
    end
  end

  assign stat_rd_grants    = r_stat_rd_grants;
  assign stat_wr_count     = r_stat_wr_count;
  assign stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule

// File: tb/tb_tbl_ram_arbiter.sv
// Self-checking bench for tbl_ram_arbiter: directed cycle table, hand-written
// reset and back-to-back sequences, then random traffic against a queue model.
module tb_tbl_ram_arbiter;
  import tbl_ram_pkg::*;

  localparam int AB     = 5;
  localparam int DB     = 38;
  localparam int NR     = 2;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AB;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd_req_valid;
  logic [NR-1:0]     rd_req_ready;
  logic [NR*AB-1:0]  rd_req_addr;
  logic [NR-1:0]     rd_rsp_valid;
  logic [DB-1:0]     rd_rsp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [AB-1:0]     wr_addr;
  logic [DB-1:0]     wr_data;
  logic [AB-1:0]     ram_addra;
  logic [DB-1:0]     ram_dina;
  logic              ram_ena;
  logic              ram_wea;
  logic [AB-1:0]     ram_addrb;
  logic              ram_enb;
  logic [DB-1:0]     ram_doutb;
`ifdef TBL_RAM_ARB_STATS_EN
  logic [31:0]       stat_rd_grants;
  logic [31:0]       stat_wr_count;
  logic [31:0]       stat_stall_cycles;
`endif

  always #5 clk = ~clk;

  tbl_ram_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_REQ(NR), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .ram_addra    (ram_addra),
    .ram_dina     (ram_dina),
    .ram_ena      (ram_ena),
    .ram_wea      (ram_wea),
    .ram_addrb    (ram_addrb),
    .ram_enb      (ram_enb),
    .ram_doutb    (ram_doutb)
`ifdef TBL_RAM_ARB_STATS_EN
    ,
    .stat_rd_grants    (stat_rd_grants),
    .stat_wr_count     (stat_wr_count),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  // Table RAM behind the ram_* ports: port A write, port B read with RD_LAT stages.
  logic [DB-1:0] ram_mem  [DEPTH];
  logic [DB-1:0] ram_pipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_pipe[0] <= ram_mem[ram_addrb];
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_doutb = ram_pipe[RD_LAT-1];

  function automatic logic [DB-1:0] init_val(input int i);
    return DB'(i) * 38'h10_0010_0101 + 38'h3C;
  endfunction

  // Reference model state.
  typedef struct {
    int            due;
    logic [NR-1:0] tag;
    logic [DB-1:0] data;
  } rsp_t;

  logic [DB-1:0] m_mem [DEPTH];
  rsp_t          m_q[$];
  int            m_ptr;
  bit            m_lw_v;
  int            m_lw_a;
  logic [NR-1:0] m_last_grant;
  longint        m_grants, m_writes, m_stalls;
  int            cyc;
  int            rsp_log[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: inputs are already driven; sample at the falling edge,
  // compare against the model, advance the model, then cross the rising edge.
  task automatic tick(input logic [NR-1:0] tbl_ready, input bit use_tbl);
    int            cand;
    int            ca;
    bit            coll;
    logic [NR-1:0] e_ready;
    logic [NR-1:0] e_rv;
    logic [DB-1:0] e_rd;
    @(negedge clk);
    e_ready = '0;
    cand    = -1;
    ca      = 0;
    if (rd_rsp_valid != '0) rsp_log.push_back(cyc);
    if (rst) begin
      check("rst_rd_req_ready", 64'(rd_req_ready), 64'd0);
      check("rst_rd_rsp_valid", 64'(rd_rsp_valid), 64'd0);
      check("rst_rd_rsp_data",  64'(rd_rsp_data),  64'd0);
      check("rst_wr_ready",     64'(wr_ready),     64'd0);
      check("rst_ram_port_a",   {ram_ena, ram_wea, 57'(ram_addra)}, 64'd0);
      check("rst_ram_dina",     64'(ram_dina),     64'd0);
      check("rst_ram_port_b",   {ram_enb, 58'(ram_addrb)}, 64'd0);
      m_q.delete();
      m_ptr  = 0;
      m_lw_v = 0;
      m_grants = 0; m_writes = 0; m_stalls = 0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (cand < 0 && rd_req_valid[idx]) cand = idx;
      end
      if (cand >= 0) begin
        ca   = int'(rd_req_addr[cand*AB +: AB]);
        coll = (wr_valid && int'(wr_addr) == ca) || (m_lw_v && m_lw_a == ca);
        if (!coll) e_ready[cand] = 1'b1;
      end
      e_rv = '0;
      e_rd = '0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        e_rv = m_q[0].tag;
        e_rd = m_q[0].data;
      end
      check("rd_req_ready", 64'(rd_req_ready), 64'(e_ready));
      check("wr_ready",     64'(wr_ready),     64'd1);
      check("ram_ena_wea",  {ram_ena, ram_wea}, {2{wr_valid}});
      if (wr_valid) check("ram_addra_dina", {ram_addra, ram_dina[DB-1:0]}, 64'({wr_addr, wr_data}));
      check("ram_enb",      64'(ram_enb),      64'(|e_ready));
      if (e_ready != '0) check("ram_addrb", 64'(ram_addrb), 64'(ca));
      check("rd_rsp_valid", 64'(rd_rsp_valid), 64'(e_rv));
      check("rd_rsp_data",  64'(rd_rsp_data),  64'(e_rd));
      if (use_tbl) check("tbl_ready", 64'(rd_req_ready), 64'(tbl_ready));

      if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
      if (e_ready != '0) begin
        m_q.push_back('{due: cyc + RD_LAT, tag: e_ready, data: m_mem[ca]});
        m_ptr = (cand + 1) % NR;
        m_grants++;
      end else if (rd_req_valid != '0) begin
        m_stalls++;
      end
      if (wr_valid) begin
        m_mem[wr_addr] = wr_data;
        m_writes++;
      end
      m_lw_v = wr_valid;
      m_lw_a = int'(wr_addr);
    end
    m_last_grant = e_ready;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [AB-1:0] a0;
    logic [AB-1:0] a1;
    logic          wv;
    logic [AB-1:0] wa;
    logic [DB-1:0] wd;
    logic [NR-1:0] er;
  } vec_t;

  vec_t tbl [21];
  bit            pend  [NR];
  logic [AB-1:0] paddr [NR];
  int            g0;
  longint        st0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = init_val(i);
      m_mem[i]   = init_val(i);
    end
    // Directed cycles from reset: single read, fairness, collisions, concurrency.
    tbl[0]  = '{2'b00, 5'd0,  5'd0, 1'b1, 5'd3, 38'h12345, 2'b00};
    tbl[1]  = '{2'b00, 5'd0,  5'd0, 1'b0, 5'd0, 38'h0,     2'b00};
    tbl[2]  = '{2'b00, 5'd0,  5'd0, 1'b0, 5'd0, 38'h0,     2'b00};
    tbl[3]  = '{2'b01, 5'd3,  5'd0, 1'b0, 5'd0, 38'h0,     2'b01};
    tbl[4]  = '{2'b10, 5'd0,  5'd0, 1'b0, 5'd0, 38'h0,     2'b10};
    tbl[5]  = '{2'b11, 5'd1,  5'd2, 1'b0, 5'd0, 38'h0,     2'b01};
    tbl[6]  = '{2'b11, 5'd1,  5'd2, 1'b0, 5'd0, 38'h0,     2'b10};
    tbl[7]  = '{2'b11, 5'd1,  5'd2, 1'b0, 5'd0, 38'h0,     2'b01};
    tbl[8]  = '{2'b11, 5'd1,  5'd2, 1'b0, 5'd0, 38'h0,     2'b10};
    tbl[9]  = '{2'b11, 5'd1,  5'd2, 1'b0, 5'd0, 38'h0,     2'b01};
    tbl[10] = '{2'b11, 5'd1,  5'd2, 1'b0, 5'd0, 38'h0,     2'b10};
    tbl[11] = '{2'b10, 5'd0,  5'd5, 1'b1, 5'd5, 38'hAA,    2'b00};
    tbl[12] = '{2'b10, 5'd0,  5'd5, 1'b0, 5'd0, 38'h0,     2'b00};
    tbl[13] = '{2'b10, 5'd0,  5'd5, 1'b0, 5'd0, 38'h0,     2'b10};
    tbl[14] = '{2'b00, 5'd0,  5'd0, 1'b0, 5'd0, 38'h0,     2'b00};
    tbl[15] = '{2'b01, 5'd4,  5'd0, 1'b1, 5'd7, 38'h777,   2'b01};
    tbl[16] = '{2'b00, 5'd0,  5'd0, 1'b0, 5'd0, 38'h0,     2'b00};
    tbl[17] = '{2'b11, 5'd10, 5'd9, 1'b1, 5'd9, 38'h999,   2'b00};
    tbl[18] = '{2'b11, 5'd10, 5'd9, 1'b0, 5'd0, 38'h0,     2'b00};
    tbl[19] = '{2'b11, 5'd10, 5'd9, 1'b0, 5'd0, 38'h0,     2'b10};
    tbl[20] = '{2'b01, 5'd10, 5'd0, 1'b0, 5'd0, 38'h0,     2'b01};

    cyc = 0;
    rst = 1'b1;
    rd_req_valid = '0; rd_req_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    tick('0, 0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      rd_req_valid = tbl[i].v;
      rd_req_addr  = {tbl[i].a1, tbl[i].a0};
      wr_valid     = tbl[i].wv;
      wr_addr      = tbl[i].wa;
      wr_data      = tbl[i].wd;
      tick(tbl[i].er, 1);
    end
    rd_req_valid = '0; wr_valid = 1'b0;
    repeat (RD_LAT + 1) tick('0, 0);

    // Reset right after a grant: its response must never appear.
    rd_req_valid = 2'b01; rd_req_addr = {5'd0, 5'd3};
    tick(2'b01, 1);
    rd_req_valid = '0; rst = 1'b1;
    rsp_log.delete();
    repeat (RD_LAT + 1) tick('0, 0);
    rst = 1'b0;
    rd_req_valid = 2'b11; rd_req_addr = {5'd2, 5'd1};
    tick(2'b01, 1);
    rd_req_valid = '0;
    repeat (RD_LAT + 2) tick('0, 0);
    check("post_rst_rsp_count", 64'(rsp_log.size()), 64'd1);

    // Three back-to-back grants: responses land at +RD_LAT, +RD_LAT+1, +RD_LAT+2.
`ifdef TBL_RAM_ARB_STATS_EN
    st0 = longint'(stat_rd_grants);
`else
    st0 = 0;
`endif
    rsp_log.delete();
    g0 = cyc;
    rd_req_valid = 2'b11; rd_req_addr = {5'd12, 5'd11};
    tick(2'b10, 1);
    tick(2'b01, 1);
    tick(2'b10, 1);
    rd_req_valid = '0;
    repeat (RD_LAT + 3) tick('0, 0);
    check("b2b_rsp_count", 64'(rsp_log.size()), 64'd3);
    for (int k = 0; k < 3 && k < rsp_log.size(); k++)
      check("b2b_rsp_cycle", 64'(rsp_log[k]), 64'(g0 + k + RD_LAT));
`ifdef TBL_RAM_ARB_STATS_EN
    check("b2b_stat_rd_grants", 64'(longint'(stat_rd_grants) - st0), 64'd3);
`endif

    // Random traffic on a narrow address range so collisions are frequent.
    for (int r = 0; r < NR; r++) begin pend[r] = 0; paddr[r] = '0; end
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < NR; r++) begin
        if (!pend[r]) begin
          if ($urandom_range(0, 99) < 60) begin
            pend[r]  = 1;
            paddr[r] = AB'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 99) < 5) begin
          pend[r] = 0;
        end
        rd_req_valid[r]        = pend[r];
        rd_req_addr[r*AB +: AB] = paddr[r];
      end
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = AB'($urandom_range(0, 7));
      wr_data  = DB'({$urandom(), $urandom()});
      rst      = ($urandom_range(0, 99) < 2);
      tick('0, 0);
      for (int r = 0; r < NR; r++) if (m_last_grant[r]) pend[r] = 0;
    end
    rst = 1'b0; rd_req_valid = '0; wr_valid = 1'b0;
    repeat (RD_LAT + 1) tick('0, 0);
`ifdef TBL_RAM_ARB_STATS_EN
    check("stat_rd_grants",    64'(stat_rd_grants),    64'(m_grants));
    check("stat_wr_count",     64'(stat_wr_count),     64'(m_writes));
    check("stat_stall_cycles", 64'(stat_stall_cycles), 64'(m_stalls));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
